icache_sa: RTL and testbench

Parametrised set-associative instruction cache between the IF stage and the memory controller. Replaces the direct-mapped, single-word-line cache with a victim buffer. Fetch lookups are combinational and complete in the cycle they are presented. A miss starts a line refill state machine, which streams `LINE_WORDS` words from the memory controller and installs them into a victim way chosen per set. A `flush_i` input (for `fence.i`) invalidates the whole cache in one cycle.

---
 rtl/icache_pkg.sv | 23 ++
 rtl/icache_way.sv | 57 +++++
 rtl/icache_sa.sv | 158 +++++++++++++++
 tb/tb_icache_sa.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {IDLE, REFILL, INSTALL} state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - $clog2(sets) - $clog2(line_words) - 2;
    endfunction

    // Round-robin pointers need at least one bit even for a direct-mapped cache.
    function automatic int ptr_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid/tag/data storage with combinational match and word select.
module icache_way
    import icache_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 6,
    parameter int OFF_W      = 2,
    parameter int TAG_W      = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic [IDX_W-1:0]            lk_idx,
    input  logic [TAG_W-1:0]            lk_tag,
    input  logic [OFF_W-1:0]            lk_off,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [TAG_W-1:0]            wr_tag,
    input  logic [LINE_WORDS-1:0][31:0] wr_data,
    input  logic                        wr_valid,
    output logic                        vld,
    output logic                        match,
    output logic [31:0]                 word
);

    typedef struct packed {
        logic                        valid;
        logic [TAG_W-1:0]            tag;
        logic [LINE_WORDS-1:0][31:0] data;
    } line_t;

    line_t lines [SETS];
    line_t rd;

    assign rd    = lines[lk_idx];
    assign vld   = rd.valid;
    assign match = rd.valid && (rd.tag == lk_tag);
    assign word  = rd.data[lk_off];

    // Only valid bits are reset; tag/data contents are don't-care until installed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) lines[s].valid <= 1'b0;
        end else if (rdy) begin
            if (wr_en) begin
                lines[wr_idx].tag   <= wr_tag;
                lines[wr_idx].data  <= wr_data;
                lines[wr_idx].valid <= wr_valid;
            end
            if (flush)
                for (int s = 0; s < SETS; s++) lines[s].valid <= 1'b0;
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational lookup, line refill FSM, victim selection.
module icache_sa
    import icache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [31:0]       inst_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_valid_i,
    input  logic [31:0]       mem_word_i,
    input  logic              flush_i,
    output logic [31:0]       miss_cnt_o
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int PTR_W = ptr_w(WAYS);

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             unused_addr;

    assign off         = addr_i[OFF_W+1:2];
    assign idx         = addr_i[OFF_W+2 +: IDX_W];
    assign tag         = addr_i[ADDR_W-1 -: TAG_W];
    assign unused_addr = ^addr_i[1:0];

    state_t                      state, state_nx;
    logic [WAYS-1:0]             way_hit, way_vld;
    logic [WAYS-1:0][31:0]       way_word;
    logic [SETS-1:0][PTR_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]            r_idx;
    logic [TAG_W-1:0]            r_tag;
    logic [PTR_W-1:0]            victim, victim_nx;
    logic                        had_inv, any_inv;
    logic [OFF_W-1:0]            beat_cnt;
    logic [LINE_WORDS-1:0][31:0] line_buf;
    logic                        discard;
    logic                        lookup_ok, start, beat, last_beat;
    logic [31:0]                 hit_word;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W), .OFF_W(OFF_W), .TAG_W(TAG_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .rdy      (rdy),
            .flush    (flush_i),
            .lk_idx   (idx),
            .lk_tag   (tag),
            .lk_off   (off),
            .wr_en    ((state == INSTALL) && (victim == PTR_W'(w))),
            .wr_idx   (r_idx),
            .wr_tag   (r_tag),
            .wr_data  (line_buf),
            .wr_valid (!(discard || flush_i)),
            .vld      (way_vld[w]),
            .match    (way_hit[w]),
            .word     (way_word[w])
        );
    end

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++)
            if (way_hit[w]) hit_word = hit_word | way_word[w];
    end

    assign lookup_ok = req_i && rdy && !rst && !flush_i && (state == IDLE);
    assign hit_o     = lookup_ok && (|way_hit);
    assign inst_o    = hit_o ? hit_word : '0;
    assign start     = lookup_ok && !(|way_hit);
    assign beat      = (state == REFILL) && mem_valid_i;
    assign last_beat = beat && (beat_cnt == OFF_W'(LINE_WORDS - 1));
    assign mem_req_o = (state == REFILL);
    assign busy_o    = (state != IDLE);

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        any_inv   = 1'b0;
        victim_nx = rr_ptr[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_vld[w]) begin
                any_inv   = 1'b1;
                victim_nx = PTR_W'(w);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = REFILL;
            REFILL:  if (last_beat) state_nx = INSTALL;
            INSTALL: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)      state <= IDLE;
        else if (rdy) state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            beat_cnt   <= '0;
            discard    <= 1'b0;
            miss_cnt_o <= '0;
            mem_addr_o <= '0;
            r_idx      <= '0;
            r_tag      <= '0;
            victim     <= '0;
            had_inv    <= 1'b0;
        end else if (rdy) begin
            if (start) begin
                r_idx      <= idx;
                r_tag      <= tag;
                victim     <= victim_nx;
                had_inv    <= any_inv;
                mem_addr_o <= {addr_i[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
            end
            // beat_cnt wraps back to zero on the last beat, ready for the next refill.
            if (beat) beat_cnt <= beat_cnt + 1'b1;
            if (state == INSTALL) begin
                discard <= 1'b0;
                if (!had_inv)
                    rr_ptr[r_idx] <= (rr_ptr[r_idx] == PTR_W'(WAYS - 1)) ? '0 : rr_ptr[r_idx] + 1'b1;
            end
            // A flush in INSTALL is handled by gating wr_valid, so discard is only armed in REFILL.
            if (flush_i) begin
                rr_ptr <= '0;
                if (state == REFILL) discard <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && beat) line_buf[beat_cnt] <= mem_word_i;
    end

endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: scoreboarded lookups, refill sequences and a direct-mapped small config.
module tb_icache_sa;

    logic        clk = 1'b0;
    logic        rst, rdy, req_i, mem_valid_i, flush_i;
    logic [16:0] addr_i, mem_addr_o;
    logic [31:0] mem_word_i, inst_o, miss_cnt_o;
    logic        hit_o, busy_o, mem_req_o;

    logic        s_req, s_mem_valid, s_hit, s_busy, s_mem_req;
    logic [16:0] s_addr, s_mem_addr;
    logic [31:0] s_word, s_inst, s_miss;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_sa u_dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .addr_i(addr_i),
        .hit_o(hit_o), .inst_o(inst_o), .busy_o(busy_o), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_valid_i(mem_valid_i), .mem_word_i(mem_word_i),
        .flush_i(flush_i), .miss_cnt_o(miss_cnt_o)
    );

    icache_sa #(.WAYS(1), .SETS(4), .LINE_WORDS(2), .ADDR_W(17)) u_small (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(s_req), .addr_i(s_addr),
        .hit_o(s_hit), .inst_o(s_inst), .busy_o(s_busy), .mem_req_o(s_mem_req),
        .mem_addr_o(s_mem_addr), .mem_valid_i(s_mem_valid), .mem_word_i(s_word),
        .flush_i(flush_i), .miss_cnt_o(s_miss)
    );

    typedef struct { string nm; logic hit; logic [31:0] inst; } exp_t;
    typedef struct { logic [16:0] addr; logic hit; logic [31:0] inst; } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every cycle the bench presents a fetch, the matching expectation is popped here.
    always @(negedge clk) begin
        if (req_i) begin
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got request with no expectation at %0t", $time);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.nm, "_hit"}, 64'(hit_o), 64'(mon_e.hit));
                chk({mon_e.nm, "_inst"}, 64'(inst_o), 64'(mon_e.inst));
            end
        end
        if (!$onehot0(u_dut.way_hit)) begin
            errors++;
            $display("FAIL multi_way_match: got %b expected at most one", u_dut.way_hit);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [16:0] a, input logic eh, input logic [31:0] ei, input string nm);
        req_i  = 1'b1;
        addr_i = a;
        sbq.push_back('{nm, eh, ei});
        tick();
        req_i = 1'b0;
    endtask

    task automatic add_line(input logic [16:0] a, input logic [31:0] base);
        for (int i = 0; i < 4; i++)
            vecs.push_back('{(a & 17'h1FFF0) + 17'(4 * i), 1'b1, base + 32'(i)});
    endtask

    task automatic run_vecs(input string nm);
        foreach (vecs[i]) present(vecs[i].addr, vecs[i].hit, vecs[i].inst, $sformatf("%s_%0d", nm, i));
        vecs.delete();
    endtask

    // Presents a missing address, then streams four beats; optional rdy stall / flush at a beat.
    task automatic refill(input logic [16:0] a, input logic [31:0] base, input int stall_at,
                          input int flush_at, input string nm);
        present(a, 1'b0, 32'h0, {nm, "_miss"});
        chk({nm, "_req"}, 64'(mem_req_o), 64'd1);
        chk({nm, "_maddr"}, 64'(mem_addr_o), 64'(a & 17'h1FFF0));
        for (int b = 0; b < 4; b++) begin
            if (b == stall_at) begin
                mem_valid_i = 1'b0;
                rdy = 1'b0;
                repeat (3) tick();
                chk({nm, "_stall_req"}, 64'(mem_req_o), 64'd1);
                chk({nm, "_stall_maddr"}, 64'(mem_addr_o), 64'(a & 17'h1FFF0));
                rdy = 1'b1;
            end
            mem_valid_i = 1'b1;
            mem_word_i  = base + 32'(b);
            flush_i     = (b == flush_at);
            tick();
        end
        mem_valid_i = 1'b0;
        flush_i     = 1'b0;
        chk({nm, "_install_req"}, 64'(mem_req_o), 64'd0);
        chk({nm, "_install_busy"}, 64'(busy_o), 64'd1);
        tick();
        chk({nm, "_idle_busy"}, 64'(busy_o), 64'd0);
    endtask

    task automatic s_fill(input logic [16:0] a, input logic [31:0] base, input string nm);
        s_req  = 1'b1;
        s_addr = a;
        @(negedge clk);
        chk({nm, "_miss"}, 64'(s_hit), 64'd0);
        tick();
        s_req = 1'b0;
        chk({nm, "_req"}, 64'(s_mem_req), 64'd1);
        chk({nm, "_maddr"}, 64'(s_mem_addr), 64'(a & 17'h1FFF8));
        for (int b = 0; b < 2; b++) begin
            s_mem_valid = 1'b1;
            s_word      = base + 32'(b);
            tick();
        end
        s_mem_valid = 1'b0;
        tick();
    endtask

    task automatic s_look(input logic [16:0] a, input logic [31:0] ei, input string nm);
        s_req  = 1'b1;
        s_addr = a;
        @(negedge clk);
        chk({nm, "_hit"}, 64'(s_hit), 64'd1);
        chk({nm, "_inst"}, 64'(s_inst), 64'(ei));
        tick();
        s_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; req_i = 1'b0; addr_i = '0; flush_i = 1'b0;
        mem_valid_i = 1'b0; mem_word_i = '0;
        s_req = 1'b0; s_addr = '0; s_mem_valid = 1'b0; s_word = '0;
        tick();
        tick();
        chk("rst_hit", 64'(hit_o), 64'd0);
        chk("rst_inst", 64'(inst_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_mreq", 64'(mem_req_o), 64'd0);
        chk("rst_maddr", 64'(mem_addr_o), 64'd0);
        chk("rst_miss", 64'(miss_cnt_o), 64'd0);
        rst = 1'b0;

        // Cold miss: first hit lands six cycles after the miss cycle.
        refill(17'h00010, 32'hA0, -1, -1, "cold");
        add_line(17'h00010, 32'hA0);
        run_vecs("cold_hit");
        chk("cold_miss_cnt", 64'(miss_cnt_o), 64'd1);

        // Conflict in set 0: two fills use both ways, the third evicts way 0.
        refill(17'h00000, 32'hB0, -1, -1, "conf_a");
        refill(17'h00400, 32'hC0, -1, -1, "conf_b");
        add_line(17'h00000, 32'hB0);
        add_line(17'h00400, 32'hC0);
        add_line(17'h00010, 32'hA0);
        run_vecs("conf_both");
        refill(17'h00800, 32'hD0, -1, -1, "conf_c");
        add_line(17'h00400, 32'hC0);
        add_line(17'h00800, 32'hD0);
        run_vecs("conf_after_evict");
        refill(17'h00000, 32'hE0, -1, -1, "conf_a_again");
        add_line(17'h00800, 32'hD0);
        add_line(17'h00000, 32'hE0);
        run_vecs("conf_rr");
        chk("conf_miss_cnt", 64'(miss_cnt_o), 64'd5);

        // Flush in IDLE together with a miss: flush wins, no refill starts.
        flush_i = 1'b1;
        present(17'h00020, 1'b0, 32'h0, "flush_idle");
        flush_i = 1'b0;
        chk("flush_idle_busy", 64'(busy_o), 64'd0);
        chk("flush_idle_mreq", 64'(mem_req_o), 64'd0);
        chk("flush_idle_miss_cnt", 64'(miss_cnt_o), 64'd5);
        refill(17'h00010, 32'h50, -1, -1, "post_flush");
        chk("post_flush_miss_cnt", 64'(miss_cnt_o), 64'd6);

        // Flush during beat 2: line is discarded, the same address misses again.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_miss", 64'(miss_cnt_o), 64'd0);
        refill(17'h00040, 32'hF0, -1, 2, "flushmid");
        refill(17'h00040, 32'h60, -1, -1, "flushmid_again");
        chk("flushmid_miss_cnt", 64'(miss_cnt_o), 64'd2);
        add_line(17'h00040, 32'h60);
        run_vecs("flushmid_hit");

        // Reset after beat 1; later beats must be ignored.
        present(17'h00080, 1'b0, 32'h0, "rstmid_miss");
        mem_valid_i = 1'b1; mem_word_i = 32'h11; tick();
        mem_word_i = 32'h22; tick();
        mem_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_mreq", 64'(mem_req_o), 64'd0);
        chk("rstmid_miss_cnt", 64'(miss_cnt_o), 64'd0);
        mem_valid_i = 1'b1; mem_word_i = 32'hBAD; tick(); tick();
        mem_valid_i = 1'b0;
        chk("rstmid_stray_busy", 64'(busy_o), 64'd0);
        refill(17'h00040, 32'h30, -1, -1, "rstmid_relook");
        refill(17'h00080, 32'h90, -1, -1, "rstmid_fill");
        add_line(17'h00040, 32'h30);
        add_line(17'h00080, 32'h90);
        run_vecs("rstmid_hit");

        // rdy stall between beats 1 and 2, and a frozen lookup.
        refill(17'h000C0, 32'h70, 2, -1, "stall");
        add_line(17'h000C0, 32'h70);
        run_vecs("stall_hit");
        rdy = 1'b0;
        present(17'h000C0, 1'b0, 32'h0, "rdy_low");
        rdy = 1'b1;
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        // Direct-mapped: 0x00000 and 0x00020 share set 0; 0x00010 is set 2.
        s_fill(17'h00000, 32'h100, "s_a");
        s_look(17'h00000, 32'h100, "s_a0");
        s_look(17'h00004, 32'h101, "s_a1");
        s_fill(17'h00020, 32'h200, "s_b");
        s_look(17'h00024, 32'h201, "s_b1");
        s_fill(17'h00000, 32'h300, "s_a_evicted");
        s_fill(17'h00010, 32'h400, "s_c");
        s_look(17'h00000, 32'h300, "s_a_kept");
        s_look(17'h00014, 32'h401, "s_c1");
        s_fill(17'h00020, 32'h500, "s_b_evicted");
        chk("s_miss_cnt", 64'(s_miss), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
